// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - shared widths, op encodings and FSM state codes for the iterative MDU
package mdu_iter_pkg;

    localparam int LENGTH = 32;
    localparam int ITER   = LENGTH;
    localparam int CNT_W  = $clog2(ITER);

    localparam logic [LENGTH-1:0] INITIAL_VAL_32 = '0;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // op[1] selects divide, op[0] selects the unsigned variant
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - operand magnitude extraction and result sign correction for the MDU
//
// Purpose: purely combinational. Produces unsigned magnitudes of the operands for signed
//          ops, and turns an unsigned raw {hi,lo} into the architectural result, including
//          the divide-by-zero result.
// Ports:
//   i_op      op encoding (MULT/MULTU/DIV/DIVU)
//   i_a/i_b   raw operands (dividend/multiplicand, divisor/multiplier)
//   i_raw_hi  unsigned product[63:32] or remainder
//   i_raw_lo  unsigned product[31:0] or quotient
//   o_mag_a/o_mag_b  operand magnitudes
//   o_hi/o_lo        corrected result
module mdu_sign_fix
    import mdu_iter_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [LENGTH-1:0] i_a,
    input  logic [LENGTH-1:0] i_b,
    input  logic [LENGTH-1:0] i_raw_hi,
    input  logic [LENGTH-1:0] i_raw_lo,
    output logic [LENGTH-1:0] o_mag_a,
    output logic [LENGTH-1:0] o_mag_b,
    output logic [LENGTH-1:0] o_hi,
    output logic [LENGTH-1:0] o_lo
);

    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [2*LENGTH-1:0]   w_raw;
    logic [2*LENGTH-1:0]   w_raw_neg;

    assign w_neg_a   = op_is_signed(i_op) & i_a[LENGTH-1];
    assign w_neg_b   = op_is_signed(i_op) & i_b[LENGTH-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31
    assign o_mag_a   = w_neg_a ? ('0 - i_a) : i_a;
    assign o_mag_b   = w_neg_b ? ('0 - i_b) : i_b;
    assign w_raw     = {i_raw_hi, i_raw_lo};
    assign w_raw_neg = '0 - w_raw;

    always_comb begin
        o_hi = i_raw_hi;
        o_lo = i_raw_lo;
        if (op_is_div(i_op)) begin
            if (i_b == '0) begin
                // divide by zero: all-ones quotient, raw dividend as remainder
                o_hi = i_a;
                o_lo = '1;
            end else begin
                // truncating division: quotient takes the xor of signs, remainder the dividend's
                o_lo = (w_neg_a ^ w_neg_b) ? ('0 - i_raw_lo) : i_raw_lo;
                o_hi = w_neg_a ? ('0 - i_raw_hi) : i_raw_hi;
            end
        end else if (w_neg_a ^ w_neg_b) begin
            o_hi = w_raw_neg[2*LENGTH-1:LENGTH];
            o_lo = w_raw_neg[LENGTH-1:0];
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MIPS multiply/divide unit driving the HI/LO writeback register
//
// Purpose: MULT/MULTU by radix-2 shift-add, DIV/DIVU by radix-2 restoring division, one bit
//          per cycle over ITER cycles. Optional macro MDU_FAST_MUL_EN routes multiplies
//          through a single-cycle array multiplier (IDLE -> DONE directly).
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    launch operation (sampled only in IDLE)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    multiplicand / dividend
//   src_b    multiplier / divisor
//   flush    abort the in-flight operation, no write
//   busy     high whenever not IDLE
//   hi_out   product[63:32] / remainder
//   lo_out   product[31:0] / quotient
//   wen_out  one-cycle write pulse in DONE
module mdu_iter
    import mdu_iter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LENGTH-1:0] src_a,
    input  logic [LENGTH-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic [LENGTH-1:0] hi_out,
    output logic [LENGTH-1:0] lo_out,
    output logic              wen_out
);

    mdu_state_e            r_state;
    mdu_state_e            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_op;
    logic [LENGTH-1:0]     r_a;
    logic [LENGTH-1:0]     r_b;
    // shared working register: {acc_hi, multiplier} for multiply, {rem, quot} for divide
    logic [2*LENGTH-1:0]   r_acc;

    logic                  w_idle;
    logic                  w_fast;
    logic [1:0]            w_fix_op;
    logic [LENGTH-1:0]     w_fix_a;
    logic [LENGTH-1:0]     w_fix_b;
    logic [LENGTH-1:0]     w_mag_a;
    logic [LENGTH-1:0]     w_mag_b;
    logic [LENGTH-1:0]     w_fix_hi;
    logic [LENGTH-1:0]     w_fix_lo;
    logic [2*LENGTH-1:0]   w_raw;
    logic [2*LENGTH-1:0]   w_step;
    logic [LENGTH:0]       w_rem_sh;
    logic [LENGTH:0]       w_diff;
    logic [LENGTH:0]       w_sum;

    assign w_idle  = (r_state == ST_IDLE);
    assign busy    = ~w_idle;
    assign wen_out = (r_state == ST_DONE) & ~flush;

    // In IDLE the sign block sees the live inputs so magnitudes can be loaded at the start
    // edge; afterwards it sees the latched operands for the iterations and final correction.
    assign w_fix_op = w_idle ? op    : r_op;
    assign w_fix_a  = w_idle ? src_a : r_a;
    assign w_fix_b  = w_idle ? src_b : r_b;

    mdu_sign_fix u_sign_fix (
        .i_op     (w_fix_op),
        .i_a      (w_fix_a),
        .i_b      (w_fix_b),
        .i_raw_hi (w_raw[2*LENGTH-1:LENGTH]),
        .i_raw_lo (w_raw[LENGTH-1:0]),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    // One iteration of either algorithm. Both leave the result in the same {hi,lo} layout.
    always_comb begin
        w_rem_sh = r_acc[2*LENGTH-1:LENGTH-1];
        w_diff   = w_rem_sh - {1'b0, w_mag_b};
        w_sum    = {1'b0, r_acc[2*LENGTH-1:LENGTH]} + (r_acc[0] ? {1'b0, w_mag_a} : '0);
        w_step   = r_acc;
        if (op_is_div(r_op)) begin
            if (w_diff[LENGTH])
                w_step = {w_rem_sh[LENGTH-1:0], r_acc[LENGTH-2:0], 1'b0};
            else
                w_step = {w_diff[LENGTH-1:0], r_acc[LENGTH-2:0], 1'b1};
        end else begin
            w_step = {w_sum, r_acc[LENGTH-1:1]};
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*LENGTH-1:0] w_fast_prod;
    assign w_fast_prod = (2*LENGTH)'(w_mag_a) * (2*LENGTH)'(w_mag_b);
    assign w_fast      = start & ~op_is_div(op);
    assign w_raw       = w_idle ? w_fast_prod : w_step;
`else
    assign w_fast      = 1'b0;
    assign w_raw       = w_step;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next = w_fast ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush)              w_next = ST_IDLE;
                else if (r_cnt == '0)   w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            hi_out  <= INITIAL_VAL_32;
            lo_out  <= INITIAL_VAL_32;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= src_a;
                        r_b   <= src_b;
                        r_cnt <= CNT_W'(ITER - 1);
                        r_acc <= op_is_div(op) ? {{LENGTH{1'b0}}, w_mag_a}
                                               : {{LENGTH{1'b0}}, w_mag_b};
                        if (w_fast) begin
                            hi_out <= w_fix_hi;
                            lo_out <= w_fix_lo;
                        end
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            hi_out <= w_fix_hi;
                            lo_out <= w_fix_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with directed vectors
module tb_mdu_iter;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, wen_out;
    logic [31:0] hi_out, lo_out;

    mdu_iter dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .hi_out(hi_out), .lo_out(lo_out), .wen_out(wen_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          wen_seen = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every write pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && wen_out) begin
            wen_seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wen: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("wen_hi", 64'(hi_out), 64'(mon_e.hi));
                check("wen_lo", 64'(lo_out), 64'(mon_e.lo));
                check("wen_cycle", 64'(cyc), 64'(mon_e.at));
            end
        end
    end

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input int at);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.at = at;
        sb.push_back(e);
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        int bc;
        lat = (FAST && !o[1]) ? 1 : 33;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        push_exp(eh, el, cyc + lat);
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(bc), 64'(lat));
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check({name, "_idle_timeout"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int w0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_wen", 64'(wen_out), 64'(0));
        check("reset_hi", 64'(hi_out), 64'(0));
        check("reset_lo", 64'(lo_out), 64'(0));

        run_op("divu_100_7",     OP_DIVU,  32'd100,        32'd7,        32'd2,        32'd14);
        run_op("div_m7_2",       OP_DIV,   32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",       OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,       32'hFFFF_FFFD);
        run_op("div_m7_m2",      OP_DIV,   32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
        run_op("mult_m3_5",      OP_MULT,  32'hFFFF_FFFD,  32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max",      OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("multu_shift",    OP_MULTU, 32'h1234_5678,  32'h10,       32'h1,        32'h2345_6780);
        run_op("mult_min_min",   OP_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("divu_by_zero",   OP_DIVU,  32'h1234,       32'h0,        32'h1234,     32'hFFFF_FFFF);
        run_op("div_neg_by_zero", OP_DIV,  32'hFFFF_FFF0,  32'h0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div_min_m1",     OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
        run_op("divu_max_1",     OP_DIVU,  32'hFFFF_FFFF,  32'h1,        32'h0,        32'hFFFF_FFFF);

        // flush partway through a divide: no write, outputs keep the last result
        w0 = wen_seen;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hi", 64'(hi_out), 64'(last_hi));
        check("flush_lo", 64'(lo_out), 64'(last_lo));
        repeat (40) @(negedge clk);
        check("flush_no_wen", 64'(wen_seen - w0), 64'(0));

        // reset partway through a divide
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wen", 64'(wen_out), 64'(0));
        check("rst_hi", 64'(hi_out), 64'(0));
        check("rst_lo", 64'(lo_out), 64'(0));
        last_hi = 32'h0;
        last_lo = 32'h0;
        repeat (40) @(negedge clk);
        check("rst_no_wen", 64'(wen_seen - w0), 64'(0));

        // start held high: second op launches the cycle after DONE with the new operands
        w0 = wen_seen;
        @(negedge clk);
        k = cyc;
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        push_exp(32'd2, 32'd14, k + 33);
        @(negedge clk);
        op = OP_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, k + 67);
        while (cyc < k + 35) @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");
        repeat (3) @(negedge clk);
        check("b2b_pulses", 64'(wen_seen - w0), 64'(2));

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
